// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller and its hazard decode.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STALL2,
    RESOLVE
  } brState_e;

  typedef logic [1:0] fwdSel_t;

  localparam fwdSel_t FWD_RF    = 2'b00;
  localparam fwdSel_t FWD_EXMEM = 2'b01;
  localparam fwdSel_t FWD_MEMWB = 2'b10;

  localparam int unsigned CNT_W = 16;

  // A pending write hits a source register unless that register is $zero.
  function automatic logic regHit(input logic we, input logic [4:0] wr, input logic [4:0] r);
    return we & (wr == r) & (r != 5'd0);
  endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational hazard and forwarding decode for the ID-stage branch comparator.
module branch_hazard_detect
  import branch_ctrl_pkg::*;
(
  input  logic       [4:0] idRs,
  input  logic       [4:0] idRt,
  input  logic             exRegWrite,
  input  logic             exMemRead,
  input  logic       [4:0] exWriteReg,
  input  logic             memRegWrite,
  input  logic             memMemRead,
  input  logic       [4:0] memWriteReg,
  input  logic             wbRegWrite,
  input  logic       [4:0] wbWriteReg,
  output logic       [1:0] need,
  output fwdSel_t          fwdA,
  output fwdSel_t          fwdB
);

  logic exHitA, exHitB, memHitA, memHitB, wbHitA, wbHitB;
  logic exHit, memHit;

  always_comb begin
    exHitA  = regHit(exRegWrite, exWriteReg, idRs);
    exHitB  = regHit(exRegWrite, exWriteReg, idRt);
    memHitA = regHit(memRegWrite, memWriteReg, idRs);
    memHitB = regHit(memRegWrite, memWriteReg, idRt);
    wbHitA  = regHit(wbRegWrite, wbWriteReg, idRs);
    wbHitB  = regHit(wbRegWrite, wbWriteReg, idRt);
    exHit   = exHitA | exHitB;
    memHit  = memHitA | memHitB;

    need = 2'd0;
    if (exMemRead & exHit)
      need = 2'd2;
    else if (exHit | (memMemRead & memHit))
      need = 2'd1;

    // A load in MEM has no data yet, so it cannot feed the comparator.
    fwdA = FWD_RF;
    if (memHitA & ~memMemRead)
      fwdA = FWD_EXMEM;
    else if (wbHitA)
      fwdA = FWD_MEMWB;

    fwdB = FWD_RF;
    if (memHitB & ~memMemRead)
      fwdB = FWD_EXMEM;
    else if (wbHitB)
      fwdB = FWD_MEMWB;
  end

endmodule

// File: rtl/branch_resolve_controller.sv
// ID-stage branch resolution: stalls on operand hazards, selects forwarding, and counts stalls/taken branches.
module branch_resolve_controller
  import branch_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_reg,
  input  logic             zero,
  input  logic             cnt_clear,
  output logic             stall,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_src,
  output logic             if_flush,
  output logic [CNT_W-1:0] taken_count,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  brState_e         state, stateNext;
  logic [1:0]       need;
  fwdSel_t          hzFwdA, hzFwdB;
  logic             branch, taken, resolve;
  logic [CNT_W-1:0] takenCnt, stallCnt;

  branch_hazard_detect uHazard (
    .idRs        (id_rs),
    .idRt        (id_rt),
    .exRegWrite  (ex_reg_write),
    .exMemRead   (ex_mem_read),
    .exWriteReg  (ex_write_reg),
    .memRegWrite (mem_reg_write),
    .memMemRead  (mem_mem_read),
    .memWriteReg (mem_write_reg),
    .wbRegWrite  (wb_reg_write),
    .wbWriteReg  (wb_write_reg),
    .need        (need),
    .fwdA        (hzFwdA),
    .fwdB        (hzFwdB)
  );

  always_comb begin
    branch    = id_beq | id_bne;
    taken     = (id_bne & ~id_beq) ? ~zero : zero;
    stateNext = state;
    stall     = 1'b0;
    resolve   = 1'b0;

    case (state)
      IDLE: begin
        if (branch) begin
          if (need == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall     = 1'b1;
            stateNext = (need == 2'd2) ? STALL2 : RESOLVE;
          end
        end
      end
      STALL2: begin
        stall     = 1'b1;
        stateNext = RESOLVE;
      end
      RESOLVE: begin
        resolve   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // Outputs are quiet while reset is held, even if the inputs still show a branch.
    if (!reset) begin
      stall   = 1'b0;
      resolve = 1'b0;
    end

    pc_src   = resolve & branch & taken;
    if_flush = pc_src;
    fwd_a    = resolve ? hzFwdA : FWD_RF;
    fwd_b    = resolve ? hzFwdB : FWD_RF;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      takenCnt <= '0;
      stallCnt <= '0;
    end else begin
      state <= stateNext;
      if (cnt_clear) begin
        takenCnt <= '0;
        stallCnt <= '0;
      end else begin
        if (stall && stallCnt != CNT_MAX)
          stallCnt <= stallCnt + 1'b1;
        if (pc_src && takenCnt != CNT_MAX)
          takenCnt <= takenCnt + 1'b1;
      end
    end
  end

  assign taken_count = takenCnt;
  assign stall_count = stallCnt;

endmodule

// File: tb/tb_branch_resolve_controller.sv
// Randomized and directed checks of branch_resolve_controller against a queue-based schedule model.
module tb_branch_resolve_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_beq, id_bne;
  logic [4:0]  id_rs, id_rt;
  logic        ex_reg_write, ex_mem_read;
  logic [4:0]  ex_write_reg;
  logic        mem_reg_write, mem_mem_read;
  logic [4:0]  mem_write_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic        zero, cnt_clear;
  logic        stall, pc_src, if_flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] taken_count, stall_count;

  int nChecks = 0;
  int nErrors = 0;

  // Upcoming forced cycle kinds after a stall starts: 1 = stall, 2 = resolve.
  int          sched[$];
  int unsigned mTaken, mStall;

  branch_resolve_controller dut (
    .clk           (clk),
    .reset         (reset),
    .id_beq        (id_beq),
    .id_bne        (id_bne),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_write_reg  (ex_write_reg),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_write_reg (mem_write_reg),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .zero          (zero),
    .cnt_clear     (cnt_clear),
    .stall         (stall),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .pc_src        (pc_src),
    .if_flush      (if_flush),
    .taken_count   (taken_count),
    .stall_count   (stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit(input bit we, input logic [4:0] wr, input logic [4:0] r);
    return we && (wr == r) && (r != 5'd0);
  endfunction

  function automatic int needOf();
    bit exAny, memAny;
    exAny  = hit(ex_reg_write, ex_write_reg, id_rs) || hit(ex_reg_write, ex_write_reg, id_rt);
    memAny = hit(mem_reg_write, mem_write_reg, id_rs) || hit(mem_reg_write, mem_write_reg, id_rt);
    if (ex_mem_read && exAny) return 2;
    if (exAny || (mem_mem_read && memAny)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] fwdOf(input logic [4:0] r);
    if (hit(mem_reg_write, mem_write_reg, r) && !mem_mem_read) return 2'b01;
    if (hit(wb_reg_write, wb_write_reg, r)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clearIn();
    id_beq = 0; id_bne = 0; id_rs = 0; id_rt = 0;
    ex_reg_write = 0; ex_mem_read = 0; ex_write_reg = 0;
    mem_reg_write = 0; mem_mem_read = 0; mem_write_reg = 0;
    wb_reg_write = 0; wb_write_reg = 0; zero = 0; cnt_clear = 0;
  endtask

  // Called just after a falling edge with inputs already driven; ends at the next falling edge.
  task automatic cycle();
    bit eStall, ePc, resolveNow, br, tk;
    logic [1:0] eFa, eFb;
    int n, kind;
    #1;
    br = id_beq || id_bne;
    tk = (id_bne && !id_beq) ? !zero : zero;
    eStall = 0; ePc = 0; resolveNow = 0; eFa = 2'b00; eFb = 2'b00;
    if (!reset) begin
      sched.delete();
      mTaken = 0;
      mStall = 0;
    end else if (sched.size() > 0) begin
      kind = sched.pop_front();
      if (kind == 1) eStall = 1;
      else resolveNow = 1;
    end else if (br) begin
      n = needOf();
      if (n == 0) resolveNow = 1;
      else begin
        eStall = 1;
        for (int i = 1; i < n; i++) sched.push_back(1);
        sched.push_back(2);
      end
    end
    if (resolveNow) begin
      eFa = fwdOf(id_rs);
      eFb = fwdOf(id_rt);
      ePc = br && tk;
    end
    checkVal("stall", stall, eStall);
    checkVal("pc_src", pc_src, ePc);
    checkVal("if_flush", if_flush, ePc);
    checkVal("fwd_a", fwd_a, eFa);
    checkVal("fwd_b", fwd_b, eFb);
    checkVal("taken_count", taken_count, mTaken);
    checkVal("stall_count", stall_count, mStall);
    if (reset) begin
      if (cnt_clear) begin
        mTaken = 0;
        mStall = 0;
      end else begin
        if (eStall && mStall < 65535) mStall++;
        if (ePc && mTaken < 65535) mTaken++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    mTaken = 0;
    mStall = 0;
    clearIn();
    reset = 0;
    @(negedge clk);
    cycle();
    cycle();
    reset = 1;
    cycle();

    // No hazard, BEQ taken in the same cycle
    id_beq = 1; id_rs = 8; id_rt = 9; zero = 1;
    #1;
    checkVal("nohaz_stall", stall, 0);
    checkVal("nohaz_pc_src", pc_src, 1);
    checkVal("nohaz_flush", if_flush, 1);
    checkVal("nohaz_fwd", {fwd_a, fwd_b}, 4'b0000);
    cycle();
    clearIn();
    #1 checkVal("nohaz_taken_count", taken_count, 1);
    cycle();

    // ALU hazard on rs, writer moves to MEM
    id_bne = 1; id_rs = 8; id_rt = 9; ex_reg_write = 1; ex_write_reg = 8;
    #1 checkVal("alu_stall", stall, 1);
    cycle();
    ex_reg_write = 0; mem_reg_write = 1; mem_write_reg = 8; zero = 0;
    #1;
    checkVal("alu_fwd_a", fwd_a, 2'b01);
    checkVal("alu_pc_src", pc_src, 1);
    checkVal("alu_stall_rel", stall, 0);
    cycle();
    clearIn();
    #1 checkVal("alu_stall_count", stall_count, 1);
    cycle();

    // Load-use on rt: two stalls, then resolve from MEM/WB
    cnt_clear = 1;
    cycle();
    clearIn();
    id_beq = 1; id_rt = 10; ex_reg_write = 1; ex_mem_read = 1; ex_write_reg = 10;
    cycle();
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 1; mem_mem_read = 1; mem_write_reg = 10;
    #1 checkVal("load_stall2", stall, 1);
    cycle();
    mem_reg_write = 0; mem_mem_read = 0; wb_reg_write = 1; wb_write_reg = 10; zero = 1;
    #1 checkVal("load_fwd_b", fwd_b, 2'b10);
    cycle();
    clearIn();
    #1 checkVal("load_stall_count", stall_count, 2);
    cycle();

    // $zero is never a hazard
    id_beq = 1; id_rs = 0; ex_reg_write = 1; ex_write_reg = 0;
    #1 checkVal("zero_guard_stall", stall, 0);
    cycle();
    clearIn();

    // Reset asserted while in STALL2
    id_beq = 1; id_rt = 10; ex_reg_write = 1; ex_mem_read = 1; ex_write_reg = 10;
    cycle();
    reset = 0;
    #1;
    checkVal("rst_mid_stall", stall, 0);
    checkVal("rst_mid_cnt", stall_count, 0);
    cycle();
    clearIn();
    reset = 1;
    cycle();
    id_beq = 1; id_rs = 3; zero = 1;
    #1 checkVal("rst_release_idle", pc_src, 1);
    cycle();
    clearIn();

    // Saturation from a preloaded stall counter, then clear during a stall
    force dut.stallCnt = 16'hFFFF;
    #1 release dut.stallCnt;
    mStall = 65535;
    id_bne = 1; id_rs = 4; ex_reg_write = 1; ex_write_reg = 4;
    cycle();
    clearIn();
    #1 checkVal("sat_hold", stall_count, 16'hFFFF);
    cycle();
    id_beq = 1; id_rs = 4; ex_reg_write = 1; ex_write_reg = 4; cnt_clear = 1;
    cycle();
    clearIn();
    #1 checkVal("clear_in_stall", stall_count, 0);
    cycle();

    // Randomized traffic on a small register range so hazards are frequent
    for (int k = 0; k < 3000; k++) begin
      id_beq        = ($urandom_range(0, 2) == 0);
      id_bne        = ($urandom_range(0, 2) == 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      ex_reg_write  = $urandom_range(0, 1);
      ex_mem_read   = ($urandom_range(0, 3) == 0);
      ex_write_reg  = 5'($urandom_range(0, 3));
      mem_reg_write = $urandom_range(0, 1);
      mem_mem_read  = ($urandom_range(0, 3) == 0);
      mem_write_reg = 5'($urandom_range(0, 3));
      wb_reg_write  = $urandom_range(0, 1);
      wb_write_reg  = 5'($urandom_range(0, 3));
      zero          = $urandom_range(0, 1);
      cnt_clear     = ($urandom_range(0, 49) == 0);
      reset         = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset = 1;
    clearIn();
    cycle();

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_controller.md
BRANCH_RESOLVE_CONTROLLER -- requirements
Module: branch_resolve_controller

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 id_beq, id_bne  in  1 each  ID-stage instruction is BEQ / BNE; both high is illegal and treated as BEQ.
REQ-005 id_rs, id_rt  in  5 each  ID-stage branch source registers.
REQ-006 ex_reg_write, ex_mem_read  in  1 each; ex_write_reg  in  5  EX-stage destination info.
REQ-007 mem_reg_write, mem_mem_read  in  1 each; mem_write_reg  in  5  MEM-stage destination info.
REQ-008 wb_reg_write  in  1; wb_write_reg  in  5  WB-stage destination info.
REQ-009 zero  in  1  equality-comparator result for the forwarded ID operands.
REQ-010 cnt_clear  in  1  synchronous clear of the statistics counters.
REQ-011 stall  out  1  hold PC and IF/ID, insert bubble into ID/EX.
REQ-012 fwd_a, fwd_b  out  2 each  comparator operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write data.
REQ-013 pc_src  out  1  select branch target; if_flush  out  1  squash IF/ID.
REQ-014 taken_count, stall_count  out  16 each  statistics.

Function
REQ-015 branch = id_beq | id_bne; hit(X,r) = X_reg_write & (X_write_reg == r) & (r != 0), evaluated for r = id_rs and r = id_rt.
REQ-016 need SHALL be 2 if ex_mem_read & hit(ex); else 1 if hit(ex), or mem_mem_read & hit(mem); else 0.
REQ-017 The FSM SHALL have states IDLE, STALL2, RESOLVE.
REQ-018 IDLE, branch & need==0: resolve this cycle (REQ-021), stay in IDLE.
REQ-019 IDLE, branch & need>0: stall=1, pc_src=0, if_flush=0; next state STALL2 if need==2, else RESOLVE.
REQ-020 STALL2: stall=1, next state RESOLVE unconditionally; RESOLVE: stall=0, resolve, next state IDLE.
REQ-021 A resolve cycle: taken = id_bne ? ~zero : zero when id_bne is high and id_beq is low, otherwise zero; pc_src = taken; if_flush = taken.
REQ-022 In a resolve cycle, fwd_x = 01 if hit(mem) & ~mem_mem_read for that operand; else 10 if hit(wb); else 00; MEM has priority over WB.
REQ-023 In all non-resolve cycles, fwd_a = fwd_b = 00, pc_src = 0, if_flush = 0.
REQ-024 IDLE with branch low: all outputs inactive (stall=0, pc_src=0, if_flush=0, fwd 00).
REQ-025 Outputs SHALL be combinational from state and inputs; state, stall_count, and taken_count are registered.
REQ-026 stall_count +1 each cycle stall=1; taken_count +1 each resolve cycle with taken=1; both saturate at 16'hFFFF.
REQ-027 cnt_clear SHALL override increments in the same cycle and zero both counters.
REQ-028 If branch drops while in STALL2 or RESOLVE, the FSM still completes the sequence, but pc_src and if_flush are forced to 0.

Reset
REQ-029 reset low SHALL immediately force state IDLE and taken_count = stall_count = 0.
REQ-030 While reset is low, stall, pc_src, if_flush SHALL be 0 and fwd_a, fwd_b SHALL be 00, including when reset asserts mid-stall.

Structure
REQ-031 A shared package branch_ctrl_pkg SHALL hold the FSM state enum, the fwd select constants (FWD_RF, FWD_EXMEM, FWD_MEMWB), and the counter width constant (16).
REQ-032 Hazard and forwarding decode (REQ-015, REQ-016, REQ-022) SHALL be one combinational sub-module, branch_hazard_detect; the FSM and counters stay in the top.

Verification
REQ-033 No hazard: BEQ rs=8, rt=9, no pending writes, zero=1 -> same cycle stall=0, pc_src=1, if_flush=1, fwd 00/00; taken_count=1.
REQ-034 ALU hazard: BNE rs=8, ex_reg_write=1, ex_write_reg=8, ex_mem_read=0, then the writer moves to MEM, zero=0 -> cycle 0: stall=1; cycle 1: fwd_a=01, pc_src=1; stall_count=1.
REQ-035 Load-use: BEQ rt=10, ex_mem_read=1, ex_write_reg=10 -> stall=1 for 2 cycles, then resolve with fwd_b=10; stall_count=2.
REQ-036 $zero guard: BEQ rs=0, ex_reg_write=1, ex_write_reg=0 -> need=0, no stall, fwd 00.
REQ-037 Reset mid-sequence: reset low in STALL2 -> stall=0 immediately, counters 0, and state IDLE on release.
REQ-038 Saturation and clear: stall_count preloaded to FFFF and a further stall -> count holds FFFF; cnt_clear during a stall -> 0 next cycle.
